// File: rtl/counter_bank.sv
// Bank of CHANNELS independent up/down counters with sticky overflow flags and registered readback.
// Define COUNTER_BANK_MATCH_EN to add per-channel compare registers and one-cycle match pulses.
module counter_bank #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4,
    parameter int SATURATE = 0,
    localparam int SELW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [CHANNELS-1:0]       inc,
    input  logic [CHANNELS-1:0]       dec,
    input  logic [CHANNELS-1:0]       clr,
    input  logic [SELW-1:0]           sel,
    input  logic                      load_en,
    input  logic [WIDTH-1:0]          load_data,
    input  logic [CHANNELS-1:0]       ovf_clr,
    input  logic                      cmp_we,
    output logic [CHANNELS-1:0]       ovf,
    output logic [CHANNELS*WIDTH-1:0] cnt_flat,
    output logic [WIDTH-1:0]          rd_data,
    output logic [CHANNELS-1:0]       match
);

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};

    logic [WIDTH-1:0]    cnt_r     [CHANNELS];
    logic [WIDTH-1:0]    cnt_nxt_s [CHANNELS];
    logic [CHANNELS-1:0] ovf_r;
    logic [CHANNELS-1:0] ovf_set_s;
    logic [WIDTH-1:0]    rd_r;
    logic [WIDTH-1:0]    rd_nxt_s;

    // Next counter value and overflow event per channel, in priority clr > load > inc/dec > hold.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_nxt_s[i] = cnt_r[i];
            ovf_set_s[i] = 1'b0;
            if (clr[i]) begin
                cnt_nxt_s[i] = ALL_ZERO;
            end else if (load_en && (sel == SELW'(i))) begin
                cnt_nxt_s[i] = load_data;
            end else if (inc[i] && !dec[i]) begin
                if (cnt_r[i] == ALL_ONES) begin
                    ovf_set_s[i] = 1'b1;
                    cnt_nxt_s[i] = (SATURATE != 0) ? ALL_ONES : ALL_ZERO;
                end else begin
                    cnt_nxt_s[i] = cnt_r[i] + {{(WIDTH-1){1'b0}}, 1'b1};
                end
            end else if (dec[i] && !inc[i]) begin
                if (cnt_r[i] == ALL_ZERO) begin
                    ovf_set_s[i] = 1'b1;
                    cnt_nxt_s[i] = (SATURATE != 0) ? ALL_ZERO : ALL_ONES;
                end else begin
                    cnt_nxt_s[i] = cnt_r[i] - {{(WIDTH-1){1'b0}}, 1'b1};
                end
            end else begin
                cnt_nxt_s[i] = cnt_r[i];
            end
        end
    end

    // Readback mux; an out-of-range sel never matches a channel and so reads 0.
    always_comb begin
        rd_nxt_s = ALL_ZERO;
        for (int i = 0; i < CHANNELS; i++) begin
            if (sel == SELW'(i)) begin
                rd_nxt_s = cnt_r[i];
            end else begin
                rd_nxt_s = rd_nxt_s;
            end
        end
    end

    // Counter, sticky flag and readback registers; a fresh overflow wins over ovf_clr.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_r[i] <= ALL_ZERO;
            end
            ovf_r <= {CHANNELS{1'b0}};
            rd_r  <= ALL_ZERO;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
            end
            ovf_r <= (ovf_r & ~ovf_clr) | ovf_set_s;
            rd_r  <= rd_nxt_s;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_flat
        assign cnt_flat[g*WIDTH +: WIDTH] = cnt_r[g];
    end

    assign ovf     = ovf_r;
    assign rd_data = rd_r;

`ifdef COUNTER_BANK_MATCH_EN
    logic [WIDTH-1:0]    cmp_r [CHANNELS];
    logic [CHANNELS-1:0] match_r;
    logic [CHANNELS-1:0] hit_s;

    // A clear is not a counting event, so it never raises match even if compare is 0.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            hit_s[i] = !clr[i] && (cnt_nxt_s[i] != cnt_r[i]) && (cnt_nxt_s[i] == cmp_r[i]);
        end
    end

    // Compare registers and match pulse; the match uses the pre-edge compare value.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < CHANNELS; i++) begin
                cmp_r[i] <= ALL_ZERO;
            end
            match_r <= {CHANNELS{1'b0}};
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (cmp_we && (sel == SELW'(i))) begin
                    cmp_r[i] <= load_data;
                end else begin
                    cmp_r[i] <= cmp_r[i];
                end
            end
            match_r <= hit_s;
        end
    end

    assign match = match_r;
`else
    // cmp_we has no function without compare registers; masking keeps it connected.
    assign match = {CHANNELS{1'b0}} & {CHANNELS{cmp_we}};
`endif

endmodule

// File: doc/counter_bank.md
COUNTER_BANK -- requirements
Module: counter_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 32, bit width of each counter (>=2).
REQ-002 SHALL have parameter CHANNELS, default 4, number of independent counters (>=1).
REQ-003 SHALL have parameter SATURATE, default 0, 0 = wrap-around on overflow/underflow, 1 = saturate at limit.
REQ-004 SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-005 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port inc  input  CHANNELS  per-channel count-up request.
REQ-007 SHALL have port dec  input  CHANNELS  per-channel count-down request.
REQ-008 SHALL have port clr  input  CHANNELS  per-channel synchronous clear to 0.
REQ-009 SHALL have port sel  input  SELW  channel index for load, compare write and readback; SELW = max(1, clog2(CHANNELS)).
REQ-010 SHALL have port load_en  input  1  load load_data into channel sel.
REQ-011 SHALL have port load_data  input  WIDTH  load/compare value.
REQ-012 SHALL have port ovf_clr  input  CHANNELS  per-channel clear of sticky overflow flag.
REQ-013 SHALL have port ovf  output  CHANNELS  sticky overflow/underflow flags.
REQ-014 SHALL have port cnt_flat  output  CHANNELS*WIDTH  all counter values, channel i at bits [i*WIDTH +: WIDTH].
REQ-015 SHALL have port rd_data  output  WIDTH  registered readback of channel sel.
REQ-016 SHALL have ports cmp_we  input  1  compare-register write, and match  output  CHANNELS  compare-match pulses.

Function
REQ-017 Per-channel update priority SHALL be: clr > load (load_en and sel==i) > inc/dec > hold.
REQ-018 inc and dec asserted together on a channel SHALL leave that counter unchanged and set no flag.
REQ-019 inc at all-ones SHALL yield 0 (SATURATE=0) or stay all-ones (SATURATE=1), and set ovf[i] on the same edge.
REQ-020 dec at 0 SHALL yield all-ones (SATURATE=0) or stay 0 (SATURATE=1), and set ovf[i] on the same edge.
REQ-021 ovf[i] SHALL remain set until ovf_clr[i]; a new overflow and ovf_clr[i] on the same edge SHALL leave ovf[i] set.
REQ-022 clr and load SHALL never set ovf.
REQ-023 load_en or cmp_we with sel >= CHANNELS SHALL be ignored; readback of such sel SHALL return 0.
REQ-024 rd_data SHALL equal, one cycle after the edge, the pre-edge value of counter sel (1-cycle latency, reads old value on simultaneous update).
REQ-025 cnt_flat SHALL reflect counter registers directly (zero combinational latency from state).

Reset
REQ-026 While resetn low at a rising edge: all counters, ovf, rd_data, match and compare registers SHALL become 0.
REQ-027 Reset SHALL override every other input, including mid-count and simultaneous load/clr.

Configuration
REQ-028 Macro COUNTER_BANK_MATCH_EN defined: per-channel WIDTH-bit compare register written with load_data on cmp_we for channel sel; match[i] SHALL pulse high exactly one cycle after an edge at which counter i changed value (inc/dec/load, not clr) and its new value equals compare i.
REQ-029 Macro COUNTER_BANK_MATCH_EN undefined: no compare registers synthesised, cmp_we ignored, match SHALL be constant 0.

Verification
REQ-030 WIDTH=4, SATURATE=0: load 15 into ch0, one inc -> cnt ch0=0, ovf[0]=1; ovf_clr[0] -> ovf[0]=0.
REQ-031 WIDTH=4, SATURATE=1: ch1 at 0, dec three cycles -> ch1 stays 0, ovf[1]=1 after first edge.
REQ-032 ch2 with inc+dec+clr all high at value 7 -> 0; inc+dec only at value 7 -> stays 7, ovf unchanged.
REQ-033 CHANNELS=3, sel=3 with load_en, load_data=5 -> no counter changes; rd_data=0 next cycle.
REQ-034 MATCH_EN: cmp ch0=3, inc ch0 from 0 for 4 cycles -> match[0] single pulse the cycle after counter reaches 3; undefined -> match stays 0.
REQ-035 Assert resetn low during counting with load_en high -> all outputs 0 on next edge; counting resumes from 0 after release.
